// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: valid/ready stream carrying a control field and a data payload
//   valid  master->slave  entry present
//   ready  slave->master  receiver accepts this cycle
//   ctrl   master->slave  CTRL_W control bits
//   data   master->slave  DATA_W payload
interface pipe_stage_reg_if #(
    parameter int CTRL_W = 5,
    parameter int DATA_W = 102
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
    modport master (output valid, ctrl, data, input ready);
    modport slave  (input valid, ctrl, data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register with flow control, flush and optional skid
//   clock      rising-edge clock
//   reset      asynchronous active-high, clears all state
//   flush      squash every held entry (and any same-cycle accept) at the next edge
//   up         slave stream from the upstream stage (in_valid/in_ready/in_ctrl/in_data)
//   dn         master stream to the downstream stage (out_valid/out_ready/out_ctrl/out_data)
//   occupancy  entries held: 0..1, or 0..2 with the skid entry
// Build option PIPE_STAGE_SKID_EN adds a second (skid) entry so in_ready is registered.
module pipe_stage_reg #(
    parameter int CTRL_W = 5,
    parameter int DATA_W = 102
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    pipe_stage_reg_if.slave        up,
    pipe_stage_reg_if.master       dn,
    output logic [1:0]             occupancy
);
    typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_t;
    state_t            state, state_nx;
    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] m_data;
    logic              acc, con, load_main;
`ifdef PIPE_STAGE_SKID_EN
    logic [CTRL_W-1:0] s_ctrl;
    logic [DATA_W-1:0] s_data;
    logic              load_skid, move_skid;
    // registered: only the skid entry being full blocks upstream
    assign up.ready = state != SKID;
`else
    assign up.ready = state == EMPTY || dn.ready;
`endif
    assign acc       = up.valid & up.ready;
    assign con       = dn.valid & dn.ready;
    assign dn.valid  = state != EMPTY;
    assign dn.ctrl   = dn.valid ? m_ctrl : '0;
    assign dn.data   = m_data;
    assign occupancy = state;
    always_comb begin
        state_nx  = state;
        load_main = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        load_skid = 1'b0;
        move_skid = 1'b0;
`endif
        case (state)
            EMPTY: begin
                load_main = acc;
                state_nx  = acc ? FULL : EMPTY;
            end
            FULL: begin
`ifdef PIPE_STAGE_SKID_EN
                // downstream stall seen one cycle late: park the new entry in the skid
                load_main = acc & con;
                load_skid = acc & ~con;
                state_nx  = load_skid ? SKID : (con & ~acc) ? EMPTY : FULL;
`else
                load_main = acc;
                state_nx  = (con & ~acc) ? EMPTY : FULL;
`endif
            end
`ifdef PIPE_STAGE_SKID_EN
            SKID: begin
                move_skid = con;
                state_nx  = con ? FULL : SKID;
            end
`endif
            default: state_nx = EMPTY;
        endcase
        if (flush) state_nx = EMPTY;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= EMPTY;
        else       state <= state_nx;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m_ctrl <= '0;
            m_data <= '0;
`ifdef PIPE_STAGE_SKID_EN
            s_ctrl <= '0;
            s_data <= '0;
`endif
        end else if (flush) begin
`ifdef PIPE_STAGE_SKID_EN
            s_ctrl <= '0;
            s_data <= '0;
`endif
        end else begin
            if (load_main) begin
                m_ctrl <= up.ctrl;
                m_data <= up.data;
            end
`ifdef PIPE_STAGE_SKID_EN
            else if (move_skid) begin
                m_ctrl <= s_ctrl;
                m_data <= s_data;
            end
            if (load_skid) begin
                s_ctrl <= up.ctrl;
                s_data <= up.data;
            end
`endif
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for pipe_stage_reg (either PIPE_STAGE_SKID_EN setting)
module tb_pipe_stage_reg;
    localparam int CW = 5;
    localparam int DW = 102;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif
    typedef logic [CW+DW-1:0] ent_t;
    logic clock = 1'b0, reset = 1'b1, flush = 1'b0;
    logic [1:0] occupancy;
    int n_chk = 0, n_fail = 0;
    ent_t q[$];
    logic [DW-1:0] held = '0;
    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) up_if ();
    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) dn_if ();
    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .up(up_if), .dn(dn_if), .occupancy(occupancy)
    );
    always #5 clock = ~clock;
    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask
    // Reference: a queue of held entries, capacity CAP; in_ready is free space
    // (or, without skid, also a same-cycle consume). Flush empties it and drops the accept.
    always @(negedge clock) begin
        logic exp_rdy, acc, con;
        if (reset) begin
            q.delete();
            held = '0;
            chk("rst_valid", dn_if.valid, 0);
            chk("rst_ctrl", dn_if.ctrl, 0);
            chk("rst_data", dn_if.data, 0);
            chk("rst_occ", occupancy, 0);
            chk("rst_ready", up_if.ready, 1);
        end else begin
            con = q.size() > 0 && dn_if.ready;
            exp_rdy = q.size() < CAP || (CAP == 1 && con);
            acc = up_if.valid && exp_rdy;
            chk("out_valid", dn_if.valid, q.size() > 0);
            chk("occupancy", occupancy, q.size());
            chk("in_ready", up_if.ready, exp_rdy);
            if (q.size() == 0) begin
                chk("bubble_ctrl", dn_if.ctrl, 0);
                chk("hold_data", dn_if.data, held);
            end else begin
                chk("out_ctrl", dn_if.ctrl, q[0][CW+DW-1:DW]);
                chk("out_data", dn_if.data, q[0][DW-1:0]);
                held = q[0][DW-1:0];
            end
            if (flush) q.delete();
            else begin
                if (con) void'(q.pop_front());
                if (acc) q.push_back({up_if.ctrl, up_if.data});
            end
        end
    end
    task automatic cyc(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic r, input logic f);
        up_if.valid = v;
        up_if.ctrl  = c;
        up_if.data  = d;
        dn_if.ready = r;
        flush       = f;
        @(posedge clock);
        #1;
    endtask
    initial begin
        up_if.valid = 1'b0;
        up_if.ctrl  = '0;
        up_if.data  = '0;
        dn_if.ready = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        // reset mid-stream
        cyc(1, 5'h1F, 102'hABC, 1, 0);
        cyc(1, 5'h1F, 102'hABC, 1, 0);
        #2 reset = 1'b1;
        #1;
        chk("async_valid", dn_if.valid, 0);
        chk("async_ctrl", dn_if.ctrl, 0);
        chk("async_data", dn_if.data, 0);
        @(posedge clock);
        #2 reset = 1'b0;
        @(posedge clock);
        #1;
        chk("post_rst_valid", dn_if.valid, 1);
        chk("post_rst_data", dn_if.data, 102'hABC);
        // streaming
        for (int i = 1; i <= 20; i++) cyc(1, CW'(i), DW'(i), 1, 0);
        chk("stream_last", dn_if.data, 20);
        // stall
        cyc(1, 5'h0A, 102'd10, 1, 0);
        cyc(1, 5'h0B, 102'd11, 0, 0);
        cyc(1, 5'h0C, 102'd12, 0, 0);
        cyc(1, 5'h0C, 102'd12, 0, 0);
        chk("stall_hold", dn_if.data, 10);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);
        // flush while full
        cyc(1, 5'h01, 102'h40, 1, 0);
        cyc(1, 5'h02, 102'h41, 0, 0);
        cyc(1, 5'h03, 102'h42, 0, 0);
        cyc(1, 5'h04, 102'h55, 0, 1);
        chk("flush_valid", dn_if.valid, 0);
        chk("flush_ctrl", dn_if.ctrl, 0);
        chk("flush_occ", occupancy, 0);
        cyc(0, 0, 0, 1, 0);
        // bubble
        cyc(1, 5'h07, 102'h77, 1, 0);
        cyc(0, 5'h1F, 102'h99, 1, 0);
        cyc(0, 5'h1F, 102'h99, 1, 0);
        chk("bubble_ctrl_d", dn_if.ctrl, 0);
        chk("bubble_data_d", dn_if.data, 102'h77);
        // random
        for (int i = 0; i < 10000; i++)
            cyc(1'($urandom_range(99) < 65), CW'($urandom),
                DW'({$urandom, $urandom, $urandom, $urandom}),
                1'($urandom_range(99) < 60), 1'($urandom_range(99) < 2));
        cyc(0, 0, 0, 1, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
